// File: rtl/tpu_pkg.sv
// Shared TPU geometry constants used to size the convolution datapath and its collectors.
package tpu_pkg;

  localparam int TPU_DATA_WIDTH        = 8;
  localparam int TPU_MATRIX_DIM        = 16;
  localparam int TPU_CONV_DIM          = 3;
  localparam int TPU_OUT_DIM           = TPU_MATRIX_DIM - TPU_CONV_DIM + 1;
  localparam int TPU_RESULTS_PER_FRAME = TPU_OUT_DIM * TPU_OUT_DIM;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock first-word fall-through FIFO; occupancy is tracked by a counter so
// full/empty never depend on pointer comparison.
module sync_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clear,
  input  logic                       push,
  input  logic                       pop,
  input  logic [DATA_WIDTH-1:0]      wr_data,
  output logic [DATA_WIDTH-1:0]      rd_data,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic                  do_push;
  logic                  do_pop;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

  // A pop frees a slot in the same cycle, so a full FIFO can still accept a push.
  assign do_pop  = pop && !empty && !clear;
  assign do_push = push && (!full || do_pop) && !clear;

  assign rd_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/tpu_result_collector.sv
// Captures TPU convolution results, applies optional ReLU, buffers them and streams
// them out over valid/ready while tracking frame boundaries and dropped results.
module tpu_result_collector
  import tpu_pkg::*;
#(
  parameter int DATA_WIDTH        = TPU_DATA_WIDTH,
  parameter int DEPTH             = 16,
  parameter int RESULTS_PER_FRAME = TPU_RESULTS_PER_FRAME
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clear,
  input  logic                       relu_en,
  input  logic                       res_done,
  input  logic [DATA_WIDTH-1:0]      res_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DATA_WIDTH-1:0]      out_data,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       overflow,
  output logic                       frame_done
);

  localparam int FW = (RESULTS_PER_FRAME > 1) ? $clog2(RESULTS_PER_FRAME) : 1;

  logic [DATA_WIDTH-1:0] stored_word;
  logic                  empty;
  logic                  pop;
  logic [FW-1:0]         frame_cnt;
  logic                  frame_last;

  assign stored_word = (relu_en && res_data[DATA_WIDTH-1]) ? '0 : res_data;
  assign out_valid   = !empty;
  assign pop         = out_valid && out_ready;
  assign frame_last  = (frame_cnt == FW'(RESULTS_PER_FRAME - 1));

  sync_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (clear),
    .push    (res_done),
    .pop     (out_ready),
    .wr_data (stored_word),
    .rd_data (out_data),
    .count   (count),
    .full    (full),
    .empty   (empty)
  );

  // A drop is only a full FIFO with nothing leaving this cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow <= 1'b0;
    end else if (clear) begin
      overflow <= 1'b0;
    end else if (res_done && full && !pop) begin
      overflow <= 1'b1;
    end
  end

  // Every pulse counts, dropped or not, so frame alignment follows the TPU scan.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt  <= '0;
      frame_done <= 1'b0;
    end else if (clear) begin
      frame_cnt  <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= res_done && frame_last;
      if (res_done) begin
        frame_cnt <= frame_last ? '0 : frame_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_tpu_result_collector.sv
// Randomised and directed bench for tpu_result_collector against a queue-based reference model.
module tb_tpu_result_collector;

  localparam int DW    = 8;
  localparam int DEPTH = 16;
  localparam int RPF   = 4;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          rst_n;
  logic          clear;
  logic          relu_en;
  logic          res_done;
  logic [DW-1:0] res_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [CW-1:0] count;
  logic          full;
  logic          overflow;
  logic          frame_done;

  int tests = 0;
  int fails = 0;

  logic [DW-1:0] model_q[$];
  bit            model_ovf;
  int            model_pulses;
  bit            model_fd;

  tpu_result_collector #(
    .DATA_WIDTH        (DW),
    .DEPTH             (DEPTH),
    .RESULTS_PER_FRAME (RPF)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (clear),
    .relu_en    (relu_en),
    .res_done   (res_done),
    .res_data   (res_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .count      (count),
    .full       (full),
    .overflow   (overflow),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] exp_data();
    return (model_q.size() > 0) ? model_q[0] : '0;
  endfunction

  function automatic logic [CW-1:0] exp_count();
    return CW'(model_q.size());
  endfunction

  task automatic model_reset();
    model_q.delete();
    model_ovf    = 0;
    model_pulses = 0;
    model_fd     = 0;
  endtask

  // Queue semantics: the consumer takes the head first, then a new result enters if there is room.
  task automatic model_edge();
    bit pop;
    if (clear) begin
      model_reset();
    end else begin
      pop      = (model_q.size() > 0) && out_ready;
      model_fd = 0;
      if (res_done) begin
        model_pulses++;
        model_fd = (model_pulses % RPF) == 0;
      end
      if (pop) void'(model_q.pop_front());
      if (res_done) begin
        if (model_q.size() < DEPTH) model_q.push_back((relu_en && res_data[DW-1]) ? '0 : res_data);
        else model_ovf = 1;
      end
    end
  endtask

  task automatic cycle(input bit d, input logic [DW-1:0] v, input bit relu, input bit rdy, input bit clr);
    res_done  = d;
    res_data  = v;
    relu_en   = relu;
    out_ready = rdy;
    clear     = clr;
    @(posedge clk);
    model_edge();
    #1;
    res_done = 0;
    clear    = 0;
  endtask

  task automatic test_reset();
    tests++; if (out_valid !== 1'b0) begin fails++; $display("[TB] FAIL reset_valid: got %0b expected 0", out_valid); end
    tests++; if (count !== '0) begin fails++; $display("[TB] FAIL reset_count: got %0d expected 0", count); end
    tests++; if (out_data !== '0) begin fails++; $display("[TB] FAIL reset_data: got %0h expected 0", out_data); end
    tests++; if ({full, overflow, frame_done} !== 3'b000) begin fails++; $display("[TB] FAIL reset_flags: got %b expected 000", {full, overflow, frame_done}); end
  endtask

  task automatic test_single();
    cycle(1, 8'h2A, 0, 0, 0);
    tests++; if (out_valid !== 1'b1) begin fails++; $display("[TB] FAIL single_valid: got %0b expected 1", out_valid); end
    tests++; if (out_data !== 8'h2A) begin fails++; $display("[TB] FAIL single_data: got %0h expected 2a", out_data); end
    tests++; if (count !== CW'(1)) begin fails++; $display("[TB] FAIL single_count: got %0d expected 1", count); end
    cycle(0, 8'h00, 0, 1, 0);
    tests++; if (out_valid !== 1'b0) begin fails++; $display("[TB] FAIL single_drain_valid: got %0b expected 0", out_valid); end
    tests++; if (count !== '0) begin fails++; $display("[TB] FAIL single_drain_count: got %0d expected 0", count); end
  endtask

  task automatic test_relu();
    cycle(1, 8'h85, 1, 0, 0);
    cycle(1, 8'h7F, 1, 0, 0);
    tests++; if (out_data !== 8'h00) begin fails++; $display("[TB] FAIL relu_neg: got %0h expected 00", out_data); end
    cycle(0, 8'h00, 0, 1, 0);
    tests++; if (out_data !== 8'h7F) begin fails++; $display("[TB] FAIL relu_pos: got %0h expected 7f", out_data); end
    cycle(0, 8'h00, 0, 1, 0);
    cycle(1, 8'h85, 0, 0, 0);
    tests++; if (out_data !== 8'h85) begin fails++; $display("[TB] FAIL relu_off: got %0h expected 85", out_data); end
    cycle(0, 8'h00, 0, 1, 0);
  endtask

  task automatic test_fill_overflow();
    cycle(0, 8'h00, 0, 0, 1);
    for (int i = 1; i <= DEPTH; i++) cycle(1, DW'(i), 0, 0, 0);
    tests++; if (full !== 1'b1 || count !== CW'(DEPTH)) begin fails++; $display("[TB] FAIL fill_full: got full=%0b count=%0d expected full=1 count=%0d", full, count, DEPTH); end
    tests++; if (overflow !== 1'b0) begin fails++; $display("[TB] FAIL fill_no_ovf: got %0b expected 0", overflow); end
    cycle(1, 8'h11, 0, 0, 0);
    tests++; if (overflow !== 1'b1 || count !== CW'(DEPTH)) begin fails++; $display("[TB] FAIL fill_ovf: got ovf=%0b count=%0d expected ovf=1 count=%0d", overflow, count, DEPTH); end
    for (int i = 1; i <= DEPTH; i++) begin
      tests++; if (out_data !== DW'(i)) begin fails++; $display("[TB] FAIL fill_drain_%0d: got %0h expected %0h", i, out_data, i); end
      cycle(0, 8'h00, 0, 1, 0);
    end
    tests++; if (out_valid !== 1'b0) begin fails++; $display("[TB] FAIL fill_drained: got %0b expected 0", out_valid); end
  endtask

  task automatic test_full_push_pop();
    cycle(0, 8'h00, 0, 0, 1);
    for (int i = 1; i <= DEPTH; i++) cycle(1, DW'(i), 0, 0, 0);
    cycle(1, 8'hAA, 0, 1, 0);
    tests++; if (count !== CW'(DEPTH) || full !== 1'b1) begin fails++; $display("[TB] FAIL fpp_count: got count=%0d full=%0b expected %0d,1", count, full, DEPTH); end
    tests++; if (overflow !== 1'b0) begin fails++; $display("[TB] FAIL fpp_ovf: got %0b expected 0", overflow); end
    for (int i = 2; i <= DEPTH + 1; i++) begin
      tests++; if (out_data !== ((i == DEPTH + 1) ? 8'hAA : DW'(i))) begin fails++; $display("[TB] FAIL fpp_drain_%0d: got %0h", i, out_data); end
      cycle(0, 8'h00, 0, 1, 0);
    end
  endtask

  task automatic test_frame();
    cycle(0, 8'h00, 0, 1, 1);
    for (int i = 1; i <= 9; i++) begin
      cycle(1, DW'($urandom), 0, 1, 0);
      tests++; if (frame_done !== ((i % RPF) == 0)) begin fails++; $display("[TB] FAIL frame_pulse_%0d: got %0b expected %0b", i, frame_done, (i % RPF) == 0); end
      cycle(0, 8'h00, 0, 1, 0);
      tests++; if (frame_done !== 1'b0) begin fails++; $display("[TB] FAIL frame_idle_%0d: got %0b expected 0", i, frame_done); end
    end
  endtask

  task automatic test_clear_mid();
    for (int i = 0; i < DEPTH + 1; i++) cycle(1, DW'($urandom), 0, 0, 0);
    cycle(1, 8'h55, 0, 0, 1);
    tests++; if (count !== '0 || out_valid !== 1'b0) begin fails++; $display("[TB] FAIL clear_empty: got count=%0d valid=%0b expected 0,0", count, out_valid); end
    tests++; if (overflow !== 1'b0 || out_data !== '0) begin fails++; $display("[TB] FAIL clear_flags: got ovf=%0b data=%0h expected 0,0", overflow, out_data); end
    for (int i = 1; i <= RPF; i++) begin
      cycle(1, 8'h01, 0, 1, 0);
      tests++; if (frame_done !== (i == RPF)) begin fails++; $display("[TB] FAIL clear_frame_%0d: got %0b expected %0b", i, frame_done, i == RPF); end
    end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < DEPTH + 2; i++) cycle(1, DW'($urandom), 0, 0, 0);
    #2 rst_n = 0;
    #1;
    model_reset();
    tests++; if (out_valid !== 1'b0 || count !== '0 || full !== 1'b0) begin fails++; $display("[TB] FAIL async_occ: got valid=%0b count=%0d full=%0b expected 0", out_valid, count, full); end
    tests++; if (overflow !== 1'b0 || out_data !== '0 || frame_done !== 1'b0) begin fails++; $display("[TB] FAIL async_flags: got ovf=%0b data=%0h fd=%0b expected 0", overflow, out_data, frame_done); end
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic test_random();
    bit rdy;
    for (int n = 0; n < 400; n++) begin
      rdy = (n < 200) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      cycle($urandom_range(0, 2) != 0, DW'($urandom), $urandom_range(0, 1) == 1, rdy, $urandom_range(0, 59) == 0);
      tests++; if (out_valid !== (model_q.size() > 0) || out_data !== exp_data()) begin fails++; $display("[TB] FAIL rand_head_%0d: got valid=%0b data=%0h expected %0b,%0h", n, out_valid, out_data, model_q.size() > 0, exp_data()); end
      tests++; if (count !== exp_count() || full !== (model_q.size() == DEPTH)) begin fails++; $display("[TB] FAIL rand_count_%0d: got %0d expected %0d", n, count, exp_count()); end
      tests++; if (overflow !== model_ovf || frame_done !== model_fd) begin fails++; $display("[TB] FAIL rand_flags_%0d: got ovf=%0b fd=%0b expected %0b,%0b", n, overflow, frame_done, model_ovf, model_fd); end
    end
  endtask

  initial begin
    rst_n     = 0;
    clear     = 0;
    relu_en   = 0;
    res_done  = 0;
    res_data  = '0;
    out_ready = 0;
    model_reset();
    #12;
    test_reset();
    @(negedge clk);
    rst_n = 1;
    test_single();
    test_relu();
    test_fill_overflow();
    test_full_push_pop();
    test_frame();
    test_clear_mid();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/tpu_result_collector.md
Name: tpu_result_collector

Overview:
- Sits directly downstream of the tpu convolution core.
- Captures each 8-bit convolution result when the core pulses done, applies optional ReLU, and buffers results in a FIFO.
- Streams buffered results to the chip output pins or host interface over a valid/ready handshake.
- Tracks frame boundaries (results per output feature map) and flags lost results.

Parameters:
- DATA_WIDTH, 8: width of one result word; matches tpu data_out.
- DEPTH, 16: FIFO entries; power of two, >= 2.
- RESULTS_PER_FRAME, 196: results per output frame, (16-3+1)^2 for the default 16x16 matrix and 3x3 kernel; must be >= 1.

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- clear  in  1  synchronous flush: empties FIFO, clears overflow and frame counter
- relu_en  in  1  1 = clamp negative results (bit MSB set) to 0 before storing
- res_done  in  1  result-valid strobe from tpu done
- res_data  in  DATA_WIDTH  result word from tpu data_out, two's complement
- out_valid  out  1  FIFO non-empty; out_data holds the head entry
- out_ready  in  1  consumer accepts head when out_valid && out_ready
- out_data  out  DATA_WIDTH  head entry (first-word fall-through)
- count  out  $clog2(DEPTH+1)  current occupancy, 0..DEPTH
- full  out  1  count == DEPTH
- overflow  out  1  sticky; set when a result is dropped
- frame_done  out  1  one-cycle pulse at end of each frame

Behaviour:
- Reset: rst_n low asynchronously forces the following:
  - write/read pointers = 0, count = 0
  - out_valid = 0, full = 0, overflow = 0, frame_done = 0
  - frame counter = 0
  - out_data = 0; storage contents need not reset, but out_data is masked to 0 while empty.
- Push: occurs when res_done = 1 and (not full, or pop in the same cycle).
  - Stored word = 0 if relu_en && res_data[DATA_WIDTH-1], else res_data.
  - relu_en is sampled in the capture cycle.
- Pop: occurs when out_valid && out_ready. The head advances on that edge; the new head appears on out_data the next cycle.
- Latency: a result pushed at edge N gives out_valid = 1 after edge N, when the FIFO was empty. There is no bypass: push and pop never happen on an empty FIFO in the same cycle.
- Full with res_done and no pop: word dropped, overflow set (stays set until clear or reset), count unchanged.
- Full with res_done and pop in the same cycle: both occur; count stays DEPTH and no overflow.
- Simultaneous push and pop when non-empty and non-full: count unchanged, both pointers advance.
- Pointer wrap: pointers are log2(DEPTH) bits and wrap DEPTH-1 -> 0; full/empty come from count, not pointer compare.
- Frame counter:
  - Increments on every res_done pulse, dropped or not, so alignment with the tpu scan is kept.
  - On the pulse that takes it to RESULTS_PER_FRAME-1 -> wrap, it resets to 0 and frame_done is registered high for exactly the next cycle.
- clear: takes priority over same-cycle push and pop. After the edge:
  - count = 0, pointers = 0, overflow = 0, frame counter = 0, frame_done = 0.
  - A res_done in the clear cycle is ignored.
- out_data and out_valid may change only on a clock edge or during reset.
- No combinational path from out_ready to out_valid.

Decomposition:
- Shared package tpu_pkg:
  - TPU_DATA_WIDTH = 8
  - TPU_MATRIX_DIM = 16
  - TPU_CONV_DIM = 3
  - TPU_OUT_DIM = TPU_MATRIX_DIM - TPU_CONV_DIM + 1
  - TPU_RESULTS_PER_FRAME = TPU_OUT_DIM squared
- This block takes its parameter defaults from the package.
- One sub-module, sync_fifo (parameterised DATA_WIDTH, DEPTH; async active-low reset), providing storage, pointers, count, full and empty.
- ReLU, overflow and frame-counter logic stay in tpu_result_collector.

Test Plan:
- Single result: reset, relu_en = 0, pulse res_done with 0x2A, out_ready = 0 -> one cycle later out_valid = 1, out_data = 0x2A, count = 1; then out_ready = 1 for one cycle -> out_valid = 0, count = 0.
- ReLU: relu_en = 1, push 0x85 then 0x7F -> output sequence 0x00, 0x7F; with relu_en = 0, 0x85 -> 0x85.
- Fill and overflow: out_ready = 0, push 0x01..0x10 -> full = 1, count = 16, overflow = 0; push 0x11 -> overflow = 1, count = 16; drain -> 0x01..0x10 in order, no 0x11.
- Full with simultaneous push and pop: with FIFO full (0x01..0x10), assert out_ready and push 0xAA in the same cycle -> count = 16, overflow = 0; full drain ends with 0xAA.
- Frame pulse: RESULTS_PER_FRAME = 4, out_ready = 1, 9 res_done pulses -> frame_done high exactly one cycle after the 4th and 8th pulses, never otherwise; drop-counting checked with out_ready = 0 and DEPTH = 2.
- Reset and clear mid-operation:
  - Push 5 words with overflow set, assert clear with a concurrent res_done -> count = 0, out_valid = 0, overflow = 0, next frame_done only after 4 new pulses.
  - Repeat with rst_n low mid-cycle -> outputs 0 immediately, without a clock edge.
